// File: rtl/data_memory.sv
// Line-oriented data memory behind the cache controller.
// Fixed-latency request/ack handshake over a 256-bit line array.
module data_memory #(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned DEPTH   = 512
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           wr_q;
    logic [8:0]     idx_q;
    logic [255:0]   wdata_q;
    logic           accept;
    logic           done;
    logic           unused_addr;

    logic [255:0]   mem [DEPTH];

    // Offset and tag bits never select a line.
    assign unused_addr = ^{addr_i[31:14], addr_i[4:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE, ACK: begin
                if (enable_i) begin
                    accept  = 1'b1;
                    cnt_d   = 8'(LATENCY - 1);
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // Counter runs down to zero so the ack lands LATENCY edges out.
                if (cnt_q == 8'd0) begin
                    done    = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            data_o  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= write_i;
                idx_q   <= addr_i[13:5];
                wdata_q <= data_i;
            end
            if (done && !wr_q) begin
                data_o <= mem[idx_q];
            end
        end
    end

    // Array has no reset; a reset during WAIT leaves state IDLE, so no write.
    always_ff @(posedge clk_i) begin
        if (done && wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign ack_o = (state_q == ACK);

endmodule

// File: tb/tb_data_memory.sv
// Randomized scoreboard bench for data_memory.
// Requests are modelled by accept edge; the monitor checks every cycle.
module tb_data_memory;

    localparam int LAT = 10;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         enable_i = 1'b0;
    logic         write_i = 1'b0;
    logic [31:0]  addr_i = '0;
    logic [255:0] data_i = '0;
    logic         ack_o;
    logic [255:0] data_o;

    data_memory #(.LATENCY(LAT), .DEPTH(512)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int           cyc;
        bit           wr;
        logic [8:0]   idx;
        logic [255:0] d;
    } req_t;

    req_t         q[$];
    int           cyc = 0;
    int           free_edge = 0;
    int           checks = 0;
    int           failures = 0;
    logic [255:0] mdl [512];
    bit           known [512];
    logic [255:0] lr = '0;
    bit           lr_known = 1'b1;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: expected ack edge and data come from the queued request.
    always @(negedge clk_i) begin
        req_t r;
        if (!rst_i) begin
            checks++;
            if (ack_o !== 1'b0 || data_o !== '0) begin
                failures++;
                $display("FAIL reset_outputs ack=%0b data=%h required ack=0 data=0",
                         ack_o, data_o);
            end
            lr = '0;
            lr_known = 1'b1;
        end else begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                r = q.pop_front();
                checks++;
                if (ack_o !== 1'b1) begin
                    failures++;
                    $display("FAIL ack_missing cycle=%0d ack=%0b required 1", cyc, ack_o);
                end
                if (r.wr) begin
                    mdl[r.idx]   = r.d;
                    known[r.idx] = 1'b1;
                end else if (known[r.idx]) begin
                    lr = mdl[r.idx];
                    lr_known = 1'b1;
                end else begin
                    lr_known = 1'b0;
                end
            end else begin
                checks++;
                if (ack_o !== 1'b0) begin
                    failures++;
                    $display("FAIL spurious_ack cycle=%0d ack=%0b required 0", cyc, ack_o);
                end
            end
            if (lr_known) begin
                checks++;
                if (data_o !== lr) begin
                    failures++;
                    $display("FAIL data_o cycle=%0d got=%h required=%h", cyc, data_o, lr);
                end
            end
        end
    end

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [31:0] line_addr(input int idx);
        logic [31:0] a;
        a = $urandom;
        a[13:5] = 9'(idx);
        return a;
    endfunction

    // Drive one request for the coming edge; the model decides acceptance.
    task automatic drive(input bit wr, input logic [31:0] a, input logic [255:0] d);
        int e;
        @(negedge clk_i);
        enable_i = 1'b1;
        write_i  = wr;
        addr_i   = a;
        data_i   = d;
        e = cyc + 1;
        if (rst_i && e >= free_edge) begin
            q.push_back('{e + LAT, wr, a[13:5], d});
            free_edge = e + LAT + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            enable_i = 1'b0;
        end
    endtask

    task automatic quiet_until_free();
        while (cyc + 2 < free_edge) begin
            @(negedge clk_i);
            enable_i = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_i);
        enable_i = 1'b0;
        #2;
        rst_i = 1'b0;
        q.delete();
        free_edge = 0;
        repeat (n) @(negedge clk_i);
        #2;
        rst_i = 1'b1;
    endtask

    initial begin
        logic [255:0] pa;
        logic [255:0] pb;
        logic [255:0] pc;
        logic [255:0] pd;
        repeat (3) @(negedge clk_i);
        #2;
        rst_i = 1'b1;

        // Preload lines 0..15 through the port.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, line_addr(i), rnd_line());
            quiet_until_free();
        end

        // Read latency on line 3 via address 0x60.
        pa = rnd_line();
        drive(1'b1, 32'h0000_0060, pa);
        quiet_until_free();
        idle(3);
        drive(1'b0, 32'h0000_0060, '0);
        idle(LAT + 3);

        // Write then read through an upper-bit alias.
        pb = rnd_line();
        drive(1'b1, 32'h0000_0060, pb);
        idle(LAT + 2);
        drive(1'b0, 32'h0000_4060, '0);
        idle(LAT + 3);

        // Writeback followed by a refill on the ack cycle.
        pc = rnd_line();
        pd = rnd_line();
        drive(1'b1, line_addr(9), pd);
        quiet_until_free();
        drive(1'b1, line_addr(7), pc);
        quiet_until_free();
        drive(1'b0, line_addr(9), '0);
        quiet_until_free();
        drive(1'b0, line_addr(7), '0);
        idle(LAT + 3);

        // Requests during WAIT must be dropped.
        drive(1'b1, line_addr(10), rnd_line());
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, line_addr(11 + (i % 2)), rnd_line());
            idle(1);
        end
        quiet_until_free();
        drive(1'b0, line_addr(11), '0);
        quiet_until_free();
        drive(1'b0, line_addr(12), '0);
        idle(LAT + 3);

        // Reset in the middle of a write to line 5.
        drive(1'b1, line_addr(5), rnd_line());
        idle(3);
        do_reset(3);
        drive(1'b0, line_addr(5), '0);
        idle(LAT + 3);

        // Enable held high: every IDLE/ACK edge accepts.
        for (int i = 0; i < 4 * (LAT + 1); i++) begin
            drive(1'(i % 3 == 0), line_addr($urandom_range(0, 15)), rnd_line());
        end
        idle(2);

        // Random traffic with random gaps.
        for (int i = 0; i < 80; i++) begin
            idle($urandom_range(0, 3));
            drive(1'($urandom_range(0, 1)), line_addr($urandom_range(0, 15)), rnd_line());
        end
        idle(1);

        for (int i = 0; i < 400 && q.size() > 0; i++) @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
